// File: rtl/frequency_generator_pkg.sv
//==============================================================================
// Module      : freq_pkg
// Description : Shared state encodings, constants and digit helper for the
//               frequency_generator stimulus source.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package freq_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        CONVERT   = 2'd1,
        ADD_UNITS = 2'd2
    } state_t;

    localparam int MAX_COUNT             = 99;
    localparam int MIN_WINDOW            = 198;
    localparam int MIN_WINDOW_PULSE      = 100;
    localparam int DEFAULT_UPDATE_PERIOD = 1200;
    localparam int VALUE_W               = $clog2(MAX_COUNT + 1);

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frequency_generator_if.sv
//==============================================================================
// Module      : frequency_generator_if
// Description : Load/control and output bundle of the frequency_generator.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface frequency_generator_if #(
    parameter int BITS = 12
);
    logic [3:0]      tens;
    logic [3:0]      units;
    logic            count_load;
    logic [BITS-1:0] period;
    logic            period_load;
    logic            signal;
    logic            window_start;
    logic            busy;

    modport master (
        output tens, units, count_load, period, period_load,
        input  signal, window_start, busy
    );

    modport slave (
        input  tens, units, count_load, period, period_load,
        output signal, window_start, busy
    );
endinterface

`default_nettype wire

// File: rtl/frequency_generator_bcd_to_bin_seq.sv
//==============================================================================
// Module      : bcd_to_bin_seq
// Description : Sequential BCD-to-binary converter (repeated add-ten), with
//               digit clamping; done pulses on the final ADD_UNITS cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_to_bin_seq
    import freq_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               start,
    input  wire logic [3:0]         tens,
    input  wire logic [3:0]         units,
    output logic                    done,
    output logic                    busy,
    output logic                    bad_state,
    output logic [VALUE_W-1:0]      value
);

    state_t               state_q, state_d;
    logic [3:0]           k_q, k_d;
    logic [3:0]           units_q, units_d;
    logic [VALUE_W-1:0]   value_q, value_d;
    logic [3:0]           tens_clamped;

    assign tens_clamped = clamp_digit(tens);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            k_q     <= 4'd0;
            units_q <= 4'd0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            units_q <= units_d;
            value_q <= value_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        units_d   = units_q;
        value_d   = value_q;
        done      = 1'b0;
        bad_state = 1'b0;
        if (start) begin
            // A zero tens digit skips straight to the units add.
            value_d = '0;
            k_d     = tens_clamped;
            units_d = clamp_digit(units);
            state_d = (tens_clamped == 4'd0) ? ADD_UNITS : CONVERT;
        end else begin
            case (state_q)
                RUN: ;
                CONVERT: begin
                    value_d = value_q + VALUE_W'(10);
                    k_d     = k_q - 4'd1;
                    if (k_q <= 4'd1) begin
                        state_d = ADD_UNITS;
                    end
                end
                ADD_UNITS: begin
                    value_d = value_q + VALUE_W'(units_q);
                    state_d = RUN;
                    done    = 1'b1;
                end
                default: begin
                    state_d   = RUN;
                    bad_state = 1'b1;
                end
            endcase
        end
    end

    assign busy  = (state_q == CONVERT) || (state_q == ADD_UNITS);
    assign value = value_q;

endmodule

`default_nettype wire

// File: rtl/frequency_generator.sv
//==============================================================================
// Module      : frequency_generator
// Description : Emits exactly N rising edges (or, with PULSE_OUT_EN defined,
//               N one-clock pulses) per window of max(update_period+1, min).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module frequency_generator
    import freq_pkg::*;
#(
    parameter int UPDATE_PERIOD = DEFAULT_UPDATE_PERIOD,
    parameter int BITS          = 12
) (
    input  wire logic       clk,
    input  wire logic       reset,
    frequency_generator_if.slave bus
);

    localparam int W_BITS = BITS + 1;
`ifdef PULSE_OUT_EN
    localparam int MIN_W  = MIN_WINDOW_PULSE;
`else
    localparam int MIN_W  = MIN_WINDOW;
`endif

    logic [BITS-1:0]    period_q, period_d;
    logic [W_BITS-1:0]  acc_q, acc_d;
    logic [W_BITS-1:0]  win_cnt_q, win_cnt_d;
    logic               signal_q, signal_d;
    logic               window_start_q, window_start_d;

    logic [W_BITS-1:0]  period_plus1;
    logic [W_BITS-1:0]  window_w;
    logic [W_BITS-1:0]  incr;
    logic [W_BITS-1:0]  sum;
    logic               fire;
    logic               start;
    logic               conv_done;
    logic               conv_busy;
    logic               conv_bad;
    logic [VALUE_W-1:0] target;

    assign start = bus.count_load | bus.period_load;

    bcd_to_bin_seq u_conv (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .tens      (bus.tens),
        .units     (bus.units),
        .done      (conv_done),
        .busy      (conv_busy),
        .bad_state (conv_bad),
        .value     (target)
    );

    assign period_plus1 = {1'b0, period_q} + W_BITS'(1);
    assign window_w     = (period_plus1 < W_BITS'(MIN_W)) ? W_BITS'(MIN_W) : period_plus1;
`ifdef PULSE_OUT_EN
    assign incr         = W_BITS'(target);
`else
    assign incr         = W_BITS'({target, 1'b0});
`endif
    assign sum          = acc_q + incr;
    assign fire         = (sum >= window_w);

    always_ff @(posedge clk) begin
        if (reset) begin
            period_q       <= BITS'(UPDATE_PERIOD);
            acc_q          <= '0;
            win_cnt_q      <= '0;
            signal_q       <= 1'b0;
            window_start_q <= 1'b0;
        end else begin
            period_q       <= period_d;
            acc_q          <= acc_d;
            win_cnt_q      <= win_cnt_d;
            signal_q       <= signal_d;
            window_start_q <= window_start_d;
        end
    end

    always_comb begin
        period_d       = period_q;
        acc_d          = acc_q;
        win_cnt_d      = win_cnt_q;
        signal_d       = signal_q;
        window_start_d = 1'b0;
        if (bus.period_load) begin
            period_d = bus.period;
        end
        if (start) begin
            acc_d     = '0;
            win_cnt_d = '0;
            signal_d  = 1'b0;
        end else if (conv_bad) begin
            acc_d    = '0;
            signal_d = 1'b0;
        end else if (conv_done) begin
            acc_d          = '0;
            win_cnt_d      = '0;
            signal_d       = 1'b0;
            window_start_d = 1'b1;
        end else if (!conv_busy) begin
            win_cnt_d = win_cnt_q + W_BITS'(1);
            acc_d     = fire ? (sum - window_w) : sum;
`ifdef PULSE_OUT_EN
            signal_d  = fire;
`else
            if (fire) begin
                signal_d = ~signal_q;
            end
`endif
            if (win_cnt_q == window_w - W_BITS'(1)) begin
                win_cnt_d      = '0;
                acc_d          = '0;
                window_start_d = 1'b1;
`ifdef PULSE_OUT_EN
                // The N-th pulse always fires on the closing cycle; keep it.
                signal_d       = fire;
`else
                signal_d       = 1'b0;
`endif
            end
        end
    end

    assign bus.signal       = signal_q;
    assign bus.window_start = window_start_q;
    assign bus.busy         = conv_busy;

endmodule

`default_nettype wire

// File: doc/frequency_generator.md
Name: frequency_generator

Overview:
Stimulus source for the frequency counter. Produces a square wave with exactly N rising edges per measurement window, where N (0..99) is loaded as two BCD digits. The window is update_period+1 clocks, the same length as the counter's count window. Used for on-chip self-test and bench loopback into the counter's signal input.

Parameters:
UPDATE_PERIOD, 1200, reset value of update_period; window = UPDATE_PERIOD+1 clocks
BITS, 12, width of period input and window counter

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
tens  input  4  BCD tens digit of target edge count
units  input  4  BCD units digit of target edge count
count_load  input  1  one-cycle strobe: capture tens/units, restart generation
period  input  BITS  new update period
period_load  input  1  one-cycle strobe: capture period, restart generation
signal  output  1  generated square wave
window_start  output  1  one-cycle pulse on first clock of each generation window
busy  output  1  high while BCD conversion is in progress

Behaviour:
- Reset (highest priority). State=RUN, target=0, update_period=UPDATE_PERIOD, acc=0, win_cnt=0. Outputs: signal=0, window_start=0, busy=0.
- Load priority below reset: period_load and count_load may assert in the same cycle; both are captured. Either strobe aborts current activity. It clears acc and win_cnt, forces signal=0, and enters CONVERT. A strobe during CONVERT restarts conversion with the new digits.
- Digit sanitising: any digit >9 is treated as 9.
- Effective window W = max(update_period+1, 198), so 2N <= W always holds.
- States:
  - CONVERT: target=0, k=tens. Each cycle, while k>0: target += 10, k -= 1. busy=1.
  - ADD_UNITS: target += units (1 cycle), busy=1, then go to RUN.
  - RUN: busy=0.
- CONVERT latency = tens cycles (0..9), plus 1 cycle for ADD_UNITS. The first RUN cycle is tens+2 cycles after the strobe, and window_start=1 on that cycle.
- RUN, every cycle:
  - s = acc + 2*target, held in BITS+1 bits.
  - If s >= W: acc <= s-W and signal toggles. Otherwise acc <= s.
  - win_cnt increments. When win_cnt = W-1: win_cnt <= 0, acc <= 0, signal <= 0, and window_start=1 on the next cycle.
- Guarantee: exactly target rising edges per window. signal is low at each window boundary.
- target=0 gives signal constantly 0. target=99 with W=198 gives a toggle every cycle.
- Widths: target 7 bits. acc, s and win_cnt BITS+1 bits with no overflow, since acc < W <= 2^BITS and 2*target <= 198.
- Any other state encoding goes to RUN with acc=0 and signal=0.

Optional Feature:
Macro PULSE_OUT_EN.
- Defined:
  - Accumulator increment is target, not 2*target.
  - When s >= W, signal is a 1-clock high pulse rather than a toggle, giving N single-cycle pulses per window.
  - Effective W = max(update_period+1, 100).
- Undefined: square-wave behaviour as specified above.

Decomposition:
- Package freq_pkg: state encodings (RUN, CONVERT, ADD_UNITS); constants MAX_COUNT=99, MIN_WINDOW=198, MIN_WINDOW_PULSE=100, DEFAULT_UPDATE_PERIOD=1200.
- Sub-module bcd_to_bin_seq: sequential repeated-add-ten converter. Ports: start, tens, units, done, value[6:0]. Owns the CONVERT/ADD_UNITS sequencing and digit clamping.

Test Plan:
- Reset, then tens=4, units=2, count_load -> busy high 5 cycles; window_start on cycle 6; exactly 42 rising edges per 1201-cycle window, over 3 windows; signal=0 at each boundary.
- tens=0, units=1 with default period -> single rise at window cycle 600, fall at cycle 1200; busy high 1 cycle.
- period=99, period_load, then tens=9, units=9, count_load -> W clamped to 198; signal toggles every cycle; 99 rises per window.
- tens=12, units=15, count_load -> target 99; busy high 10 cycles.
- count_load with tens=7 mid-RUN, then reset 3 cycles later during CONVERT -> signal=0, busy=0, target=0, update_period=1200; no edges afterwards.
- count_load and period_load in the same cycle (period=499, N=25) -> both captured; 25 rises per 500-cycle window.
